// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-locked sharing of one UART TX between NREQ byte sources,
// with a forced inter-message gap and a stall timeout.
module uart_tx_arbiter #(
  parameter int NREQ       = 3,
  parameter int GAP_CYCLES = 217,
  parameter int TIMEOUT    = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid_i,
  input  logic [NREQ*8-1:0]       req_data_i,
  input  logic [NREQ-1:0]         req_last_i,
  output logic [NREQ-1:0]         req_ready_o,
  output logic                    tx_valid_o,
  output logic [7:0]              tx_data_o,
  input  logic                    tx_ready_i,
  output logic [$clog2(NREQ)-1:0] grant_id_o,
  output logic                    busy_o,
  output logic                    timeout_err_o
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2((TIMEOUT > GAP_CYCLES ? TIMEOUT : GAP_CYCLES) + 1);
  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;
  state_t        state_q;
  logic [IW-1:0] gnt_q, last_q, pick, idx;
  logic [CW-1:0] cnt_q;
  logic          timeout_err_q, xfer, sel_valid, hs, stall;
  assign xfer          = state_q == XFER;
  assign sel_valid     = req_valid_i[gnt_q];
  assign hs            = xfer && sel_valid && tx_ready_i;
  assign stall         = xfer && !sel_valid && cnt_q == CW'(TIMEOUT - 1);
  assign tx_valid_o    = xfer && sel_valid;
  assign tx_data_o     = xfer ? req_data_i[8*gnt_q +: 8] : 8'h00;
  assign req_ready_o   = (xfer && tx_ready_i) ? (NREQ'(1) << gnt_q) : '0;
  assign grant_id_o    = gnt_q;
  assign busy_o        = state_q != IDLE;
  assign timeout_err_o = timeout_err_q;
  // Scan downward so the nearest requester after last_q is the one that sticks.
  always_comb begin
    pick = last_q;
    idx  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IW'((int'(last_q) + k) % NREQ);
      if (req_valid_i[idx]) pick = idx;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      gnt_q         <= '0;
      last_q        <= IW'(NREQ - 1);
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= 1'b0;
      case (state_q)
        IDLE: if (|req_valid_i) begin
          gnt_q   <= pick;
          last_q  <= pick;
          cnt_q   <= '0;
          state_q <= XFER;
        end
        XFER: if (hs && req_last_i[gnt_q]) begin
          cnt_q   <= '0;
          state_q <= (GAP_CYCLES == 0) ? IDLE : GAP;
        end else if (stall) begin
          timeout_err_q <= 1'b1;
          cnt_q         <= '0;
          state_q       <= (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          cnt_q <= sel_valid ? '0 : cnt_q + CW'(1);
        end
        GAP: if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus randomized multi-source traffic checked
// against a message-level round-robin model.
module tb_uart_tx_arbiter;
  localparam int NREQ = 3, GAP = 217, TO = 4096;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [2:0]  rv = '0, rl = '0, rr;
  logic [23:0] rd = '0;
  logic        tr = 1'b0, tv, busy, terr;
  logic [7:0]  td;
  logic [1:0]  gid;
  int checks = 0, errors = 0;
  logic [8:0] sq [NREQ][$];
  logic [8:0] mq [NREQ][$];
  int bub [NREQ];
  int lg_src[$], lg_byte[$], lg_last[$], lg_cyc[$];
  int exp_src[$], exp_byte[$];
  int viol, n, extra, mlast, nxt, rem [NREQ];
  bit rnd;
  logic [8:0] w;

  always #20 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(rv), .req_data_i(rd), .req_last_i(rl),
    .req_ready_o(rr), .tx_valid_o(tv), .tx_data_o(td), .tx_ready_i(tr),
    .grant_id_o(gid), .busy_o(busy), .timeout_err_o(terr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    rst_n = 1'b0; rv = '0; rl = '0; tr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int c = 0;
    #1;
    while (busy && c < 1000) begin c++; @(negedge clk); #1; end
    chk(tag, busy, 0);
  endtask

  // Serves every source from its byte queue and logs each handshake.
  task automatic run(input int maxc);
    bit done = 0;
    lg_src.delete(); lg_byte.delete(); lg_last.delete(); lg_cyc.delete();
    viol = 0;
    for (int i = 0; i < NREQ; i++) bub[i] = 0;
    for (int c = 0; c < maxc && !done; c++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        rv[i] = sq[i].size() > 0 && bub[i] == 0;
        rd[8*i +: 8] = sq[i].size() > 0 ? sq[i][0][7:0] : 8'h00;
        rl[i] = sq[i].size() > 0 && sq[i][0][8];
      end
      tr = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if ((rr & (rr - 3'd1)) != 0 || (rr != 0 && !tr) || terr) viol++;
      for (int i = 0; i < NREQ; i++) begin
        if (bub[i] > 0) bub[i]--;
        if (rv[i] && rr[i]) begin
          if (!tv || td != rd[8*i +: 8] || int'(gid) != i) viol++;
          lg_src.push_back(i); lg_byte.push_back(int'(rd[8*i +: 8]));
          lg_last.push_back(int'(rl[i])); lg_cyc.push_back(c);
          if (!rl[i] && rnd) bub[i] = $urandom_range(0, 3);
          void'(sq[i].pop_front());
        end
      end
      done = !busy;
      for (int i = 0; i < NREQ; i++) if (sq[i].size() > 0) done = 0;
    end
    rv = '0; rl = '0;
    chk("run_done", done, 1);
    chk("run_viol", viol, 0);
  endtask

  task automatic cmp_log(input string tag);
    chk({tag, "_count"}, lg_src.size(), exp_src.size());
    for (int k = 0; k < exp_src.size() && k < lg_src.size(); k++) begin
      chk({tag, "_src"}, lg_src[k], exp_src[k]);
      chk({tag, "_byte"}, lg_byte[k], exp_byte[k]);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0); chk("rst_tv", tv, 0); chk("rst_rr", rr, 0);
    chk("rst_gid", gid, 0); chk("rst_terr", terr, 0);
    @(negedge clk); rst_n = 1'b1;

    // single source, one byte
    @(negedge clk); rv = 3'b010; rd[15:8] = 8'h46; rl = 3'b010; tr = 1'b1;
    #1; chk("t1_idle_rr", rr, 0); chk("t1_idle_busy", busy, 0);
    @(negedge clk); #1;
    chk("t1_gid", gid, 1); chk("t1_tv", tv, 1); chk("t1_td", td, 8'h46); chk("t1_rr", rr, 3'b010);
    @(negedge clk); rv = '0; n = 0; extra = 0; #1;
    while (busy && n < 400) begin n++; if (tv) extra++; @(negedge clk); #1; end
    chk("t1_gap_len", n, GAP); chk("t1_gap_quiet", extra, 0);

    // contention right after reset
    rst_pulse();
    rnd = 0;
    sq[0] = '{9'h053, 9'h10A}; sq[2] = '{9'h146};
    exp_src = '{0, 0, 2}; exp_byte = '{8'h53, 8'h0A, 8'h46};
    run(2000);
    cmp_log("t2");
    if (lg_cyc.size() == 3) begin
      chk("t2_latency", lg_cyc[0], 1);
      chk("t2_gap", lg_cyc[2] - lg_cyc[1], GAP + 2);
    end

    // round-robin with everyone requesting
    sq[0] = '{9'h101, 9'h104}; sq[1] = '{9'h102, 9'h105}; sq[2] = '{9'h103, 9'h106};
    exp_src = '{0, 1, 2, 0, 1, 2}; exp_byte = '{1, 2, 3, 4, 5, 6};
    run(4000);
    cmp_log("t3");

    // long back-pressure must not time out
    @(negedge clk); rv = 3'b010; rd[15:8] = 8'hA5; rl = 3'b010; tr = 1'b0;
    n = 0; extra = 0;
    for (int k = 0; k < 5000; k++) begin
      #1;
      if (terr) n++;
      if (k > 0 && (!tv || td != 8'hA5 || rr != 0)) extra++;
      @(negedge clk);
    end
    tr = 1'b1; #1;
    chk("t4_no_timeout", n, 0); chk("t4_held", extra, 0);
    chk("t4_rr", rr, 3'b010); chk("t4_td", td, 8'hA5);
    @(negedge clk); rv = '0;
    wait_idle("t4_idle");

    // stall mid-message
    @(negedge clk); rv = 3'b101; rd[23:16] = 8'h11; rd[7:0] = 8'h22; rl = 3'b001; tr = 1'b1;
    @(negedge clk); #1;
    chk("t5_gid", gid, 2); chk("t5_rr", rr, 3'b100); chk("t5_td", td, 8'h11);
    @(negedge clk); rv = 3'b001; n = 0; #1;
    while (!terr && n < TO + 100) begin n++; @(negedge clk); #1; end
    chk("t5_delay", n, TO); chk("t5_busy", busy, 1); chk("t5_gap_tv", tv, 0);
    @(negedge clk); #1; chk("t5_pulse", terr, 0);
    n = 0;
    while (!tv && n < 500) begin n++; @(negedge clk); #1; end
    chk("t5_next_gid", gid, 0); chk("t5_next_td", td, 8'h22); chk("t5_next_rr", rr, 3'b001);
    @(negedge clk); rv = '0;
    wait_idle("t5_idle");

    // asynchronous reset mid-message
    @(negedge clk); rv = 3'b010; rd[15:8] = 8'h77; rl = 3'b000; tr = 1'b0;
    @(negedge clk); #1; chk("t6_gid", gid, 1); chk("t6_tv", tv, 1);
    #4; tr = 1'b1; #1; chk("t6_rr_pre", rr, 3'b010);
    rst_n = 1'b0; #1;
    chk("t6_tv_rst", tv, 0); chk("t6_rr_rst", rr, 0); chk("t6_busy_rst", busy, 0); chk("t6_gid_rst", gid, 0);
    rv = '0; tr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sq[0] = '{9'h1C3}; sq[1] = '{9'h177};
    exp_src = '{0, 1}; exp_byte = '{8'hC3, 8'h77};
    run(2000);
    cmp_log("t6");

    // randomized traffic against a message-level round-robin model
    exp_src.delete(); exp_byte.delete();
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = 4;
      for (int m = 0; m < 4; m++) begin
        n = $urandom_range(1, 3);
        for (int b = 0; b < n; b++) begin
          w = {b == n - 1, 8'($urandom)};
          sq[i].push_back(w); mq[i].push_back(w);
        end
      end
    end
    mlast = 1;
    for (int m = 0; m < 4 * NREQ; m++) begin
      nxt = -1;
      for (int k = NREQ; k >= 1; k--) if (rem[(mlast + k) % NREQ] > 0) nxt = (mlast + k) % NREQ;
      rem[nxt]--; mlast = nxt;
      do begin
        w = mq[nxt].pop_front();
        exp_src.push_back(nxt); exp_byte.push_back(int'(w[7:0]));
      end while (!w[8]);
    end
    rnd = 1;
    run(30000);
    cmp_log("rand");
    for (int k = 1; k < lg_cyc.size(); k++)
      if (lg_last[k-1] != 0) chk("rand_gap", lg_cyc[k] - lg_cyc[k-1] >= GAP + 2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
